// File: rtl/arbiter_pkg.sv
// Shared definitions for the two-master memory port arbiter.
// State encoding and default error word.
package arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    localparam logic [31:0] ERROR_DATA_DEF = 32'hDEADBEEF;

endpackage

// File: rtl/memory_port_arbiter_rr_grant2.sv
// Two-way round-robin grant selection.
// Pure combinational; the caller owns last_grant.
module rr_grant2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);

    assign valid = |req;
    // With both requesting, the master that did not win last time goes.
    assign grant = (&req) ? ~last_grant : req[1];

endmodule

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter for two masters sharing one memory port,
// with a watchdog that completes hung transactions with an error word.
module memory_port_arbiter
    import arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] ERROR_DATA = ERROR_DATA_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_response,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_response,
    output logic                  s_read,
    output logic                  s_write,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] s_wdata,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic                  s_response,
    output logic                  timeout_err
);

    localparam int CW = (TIMEOUT_CYCLES == 0) ? 1
                      : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TLAST =
        CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t          state;
    logic            grant;
    logic            last_grant;
    logic [CW-1:0]   cnt;

    logic [1:0]            req;
    logic                  pick;
    logic                  pick_valid;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  timed_out;
    logic                  done;
    logic [DATA_WIDTH-1:0] done_data;

    assign req = {m1_read | m1_write, m0_read | m0_write};

    rr_grant2 u_grant (
        .req        (req),
        .last_grant (last_grant),
        .grant      (pick),
        .valid      (pick_valid)
    );

    assign sel_write = pick ? m1_write : m0_write;
    assign sel_addr  = pick ? m1_addr  : m0_addr;
    assign sel_wdata = pick ? m1_wdata : m0_wdata;

    assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt == TLAST);
    // A real response in the timeout cycle wins over the abort.
    assign done      = s_response | timed_out;
    assign done_data = s_response ? s_rdata : ERROR_DATA;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            cnt         <= '0;
            s_read      <= 1'b0;
            s_write     <= 1'b0;
            s_addr      <= '0;
            s_wdata     <= '0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
            m0_response <= 1'b0;
            m1_response <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant   <= pick;
                        s_addr  <= sel_addr;
                        s_wdata <= sel_wdata;
                        s_write <= sel_write;
                        s_read  <= ~sel_write;
                        cnt     <= '0;
                        state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (done) begin
                        s_read      <= 1'b0;
                        s_write     <= 1'b0;
                        s_addr      <= '0;
                        s_wdata     <= '0;
                        timeout_err <= ~s_response;
                        if (grant) begin
                            m1_rdata    <= done_data;
                            m1_response <= 1'b1;
                        end else begin
                            m0_rdata    <= done_data;
                            m0_response <= 1'b1;
                        end
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    m0_response <= 1'b0;
                    m1_response <= 1'b0;
                    m0_rdata    <= '0;
                    m1_rdata    <= '0;
                    timeout_err <= 1'b0;
                    last_grant  <= grant;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Randomized bench for memory_port_arbiter against a transaction model.
// Watchdog is shortened to 8 cycles.
module tb_memory_port_arbiter;

    localparam int TO = 8;
    localparam logic [31:0] ERRW = 32'hDEADBEEF;

    logic        clk;
    logic        rst_n;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_response, m1_response;
    logic        s_read, s_write;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        s_response;
    logic        timeout_err;

    memory_port_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO),
        .ERROR_DATA     (ERRW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m0_read     (m0_read),
        .m0_write    (m0_write),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_rdata    (m0_rdata),
        .m0_response (m0_response),
        .m1_read     (m1_read),
        .m1_write    (m1_write),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_rdata    (m1_rdata),
        .m1_response (m1_response),
        .s_read      (s_read),
        .s_write     (s_write),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_rdata     (s_rdata),
        .s_response  (s_response),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Master-side model: pending request per master plus round-robin pointer.
    logic        pend [2];
    logic        rd   [2];
    logic        wr   [2];
    logic [31:0] addr [2];
    logic [31:0] wdat [2];
    logic        last;
    int          order [$];

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic apply();
        m0_read  = rd[0];
        m0_write = wr[0];
        m0_addr  = addr[0];
        m0_wdata = wdat[0];
        m1_read  = rd[1];
        m1_write = wr[1];
        m1_addr  = addr[1];
        m1_wdata = wdat[1];
    endtask

    task automatic set_req(input int m, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        pend[m] = 1'b1;
        rd[m]   = r;
        wr[m]   = w;
        addr[m] = a;
        wdat[m] = d;
    endtask

    task automatic clear_req(input int m);
        pend[m] = 1'b0;
        rd[m]   = 1'b0;
        wr[m]   = 1'b0;
    endtask

    function automatic logic resp_of(input int m);
        return (m == 0) ? m0_response : m1_response;
    endfunction

    function automatic logic [31:0] rdata_of(input int m);
        return (m == 0) ? m0_rdata : m1_rdata;
    endfunction

    // Called at a negedge while the DUT is idle and requests are set.
    // d = BUSY cycle on which the slave answers; d > TO means never.
    task automatic run_trial(input int d, input bit drop,
                             input logic [31:0] rval);
        int          w;
        int          lim;
        logic [31:0] er_addr, er_wdata, exp_data;
        logic        er_wr;
        w = (pend[0] && pend[1]) ? int'(!last) : int'(pend[1]);
        order.push_back(w);
        er_addr  = addr[w];
        er_wdata = wdat[w];
        er_wr    = wr[w];
        apply();
        @(posedge clk);
        @(negedge clk);
        s_response = 1'b0;
        chk("s_read",  {63'd0, s_read},  {63'd0, !er_wr});
        chk("s_write", {63'd0, s_write}, {63'd0, er_wr});
        chk("s_addr",  {32'd0, s_addr},  {32'd0, er_addr});
        chk("s_wdata", {32'd0, s_wdata}, {32'd0, er_wdata});
        lim = (d <= TO) ? d : TO;
        for (int i = 1; i <= lim; i++) begin
            if (drop && i == 1) begin
                rd[w] = 1'b0;
                wr[w] = 1'b0;
                apply();
            end
            s_response = (i == d);
            s_rdata    = (i == d) ? rval : $urandom;
            @(posedge clk);
            @(negedge clk);
            s_response = 1'b0;
            if (i < lim) begin
                chk("busy_hold",
                    {30'd0, s_read, s_write, s_addr},
                    {30'd0, !er_wr, er_wr, er_addr});
                chk("busy_noresp",
                    {62'd0, m0_response, m1_response}, 64'd0);
            end
        end
        exp_data = (d <= TO) ? rval : ERRW;
        chk("resp_win",  {63'd0, resp_of(w)},  64'd1);
        chk("resp_lose", {63'd0, resp_of(1 - w)}, 64'd0);
        chk("rdata",     {32'd0, rdata_of(w)}, {32'd0, exp_data});
        chk("tmo_err",   {63'd0, timeout_err}, {63'd0, d > TO});
        chk("s_drop",    {62'd0, s_read, s_write}, 64'd0);
        clear_req(w);
        apply();
        s_response = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        s_response = 1'b0;
        chk("resp_end",
            {29'd0, m0_response, m1_response, timeout_err, s_read, s_write},
            64'd0);
        chk("rdata_zero", {m0_rdata, m1_rdata}, 64'd0);
        last = w[0];
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {63'd0, |{m0_rdata, m0_response, m1_rdata, m1_response,
                           s_read, s_write, s_addr, s_wdata, timeout_err}},
            64'd0);
    endtask

    task automatic rand_reqs();
        for (int m = 0; m < 2; m++) begin
            if (!pend[m] && $urandom_range(0, 1) == 1) begin
                logic r;
                r = 1'($urandom_range(0, 1));
                set_req(m, r, r ? ($urandom_range(0, 3) == 0) : 1'b1,
                        $urandom, $urandom);
            end
        end
        if (!pend[0] && !pend[1]) begin
            set_req(int'($urandom_range(0, 1)), 1'b1, 1'b0,
                    $urandom, $urandom);
        end
    endtask

    task automatic pop_chk(input string tag, input int exp);
        int got;
        got = (order.size() > 0) ? order.pop_front() : -1;
        chk(tag, 64'(got), 64'(exp));
    endtask

    initial begin
        rst_n      = 1'b0;
        s_response = 1'b0;
        s_rdata    = '0;
        last       = 1'b1;
        for (int m = 0; m < 2; m++) begin
            clear_req(m);
            addr[m] = '0;
            wdat[m] = '0;
        end
        apply();
        repeat (3) @(negedge clk);
        chk_all_zero("reset_out");
        rst_n = 1'b1;
        @(negedge clk);

        set_req(0, 1'b1, 1'b0, 32'h200, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h300, 32'h0);
        run_trial(1, 1'b0, 32'h11111111);
        run_trial(3, 1'b0, 32'h22222222);
        set_req(0, 1'b0, 1'b1, 32'h204, 32'h5);
        set_req(1, 1'b0, 1'b1, 32'h304, 32'h6);
        run_trial(2, 1'b0, 32'h0);
        run_trial(2, 1'b0, 32'h0);
        pop_chk("rr_0", 0);
        pop_chk("rr_1", 1);
        pop_chk("rr_2", 0);
        pop_chk("rr_3", 1);

        set_req(0, 1'b1, 1'b0, 32'h100, 32'h0);
        run_trial(2, 1'b0, 32'h12345678);
        set_req(1, 1'b0, 1'b1, 32'h80000004, 32'hCAFEF00D);
        run_trial(4, 1'b0, 32'h0);
        set_req(0, 1'b1, 1'b1, 32'h40, 32'h77);
        run_trial(5, 1'b0, 32'h0);
        set_req(0, 1'b1, 1'b0, 32'h44, 32'h0);
        run_trial(20, 1'b0, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h48, 32'h0);
        run_trial(TO, 1'b0, 32'hA5A5A5A5);
        set_req(1, 1'b1, 1'b0, 32'h4C, 32'h0);
        run_trial(3, 1'b1, 32'h5A5A5A5A);
        order.delete();

        for (int t = 0; t < 150; t++) begin
            rand_reqs();
            s_response = 1'($urandom_range(0, 3) == 0);
            run_trial(int'($urandom_range(1, TO + 3)),
                      1'($urandom_range(0, 3) == 0), $urandom);
        end

        set_req(1, 1'b1, 1'b0, 32'h9000, 32'h0);
        apply();
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", {63'd0, s_read}, 64'd1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        clear_req(0);
        clear_req(1);
        apply();
        last = 1'b1;
        @(negedge clk);
        chk_all_zero("rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        order.delete();
        set_req(0, 1'b1, 1'b0, 32'hA0, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'hB0, 32'h0);
        run_trial(2, 1'b0, 32'h0BADF00D);
        pop_chk("post_rst_m0", 0);

        for (int t = 0; t < 100; t++) begin
            rand_reqs();
            run_trial(int'($urandom_range(1, TO + 3)),
                      1'($urandom_range(0, 3) == 0), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
